// File: rtl/id_ex_stage_pkg.sv
// Shared opcode/funct constants, control-bit indices and the ID/EX register record.
package id_ex_stage_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;

  // Bit positions inside the 5-bit decoder control word
  localparam int CTRL_W        = 5;
  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_ALUSRC   = 0;

  // Everything the EX stage remembers about one instruction; all-zero is a bubble
  typedef struct packed {
    logic [5:0]        aluop;
    logic [5:0]        funct;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        wr;
    logic              valid;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [31:0]       imm;
  } ex_regs_t;

  // Shift-by-immediate instructions take the shifted value from rt and shamt from imm
  function automatic logic is_shift(input logic [5:0] aluop, input logic [5:0] funct);
    return (aluop == OP_RTYPE) &&
           (funct == FUNCT_SLL || funct == FUNCT_SRL || funct == FUNCT_SRA);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: youngest producer (EX/MEM) wins, r0 is never forwarded.
module fwd_mux #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [4:0]  src_reg,
  input  logic [31:0] src_data,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_wr,
  input  logic [31:0] exmem_data,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_wr,
  input  logic [31:0] memwb_data,
  output logic [31:0] fwd_data
);

  // Pick the newest in-flight value for src_reg, else the value read in ID
  always_comb begin
    fwd_data = src_data;
    if (FWD_EN) begin
      if (exmem_regwrite && exmem_wr != 5'd0 && exmem_wr == src_reg)
        fwd_data = exmem_data;
      else if (memwb_regwrite && memwb_wr != 5'd0 && memwb_wr == src_reg)
        fwd_data = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, mult/div stall hold and operand forwarding.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        id_aluop,
  input  logic [5:0]        id_funct,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_wr,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic              flush,
  input  logic              stall_muldiv,
  input  logic              exmem_regwrite,
  input  logic [4:0]        exmem_wr,
  input  logic [31:0]       exmem_data,
  input  logic              memwb_regwrite,
  input  logic [4:0]        memwb_wr,
  input  logic [31:0]       memwb_data,
  output logic [5:0]        ALUOp_regD,
  output logic [5:0]        funct_regD,
  output logic [31:0]       ALUinA,
  output logic [31:0]       ALUinB,
  output logic [3:0]        ex_ctrl,
  output logic [4:0]        ex_wr,
  output logic [31:0]       ex_store_data,
  output logic              ex_valid,
  output logic              hold_id
);

  ex_regs_t    ex_q;
  ex_regs_t    ex_d;
  logic        loaduse;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  // A load in EX whose destination is read by the ID instruction must be held back a cycle
  always_comb begin
    loaduse = id_valid && ex_q.valid && ex_q.ctrl[CTRL_MEMREAD] && (ex_q.wr != 5'd0) &&
              ((ex_q.wr == id_rs) || (ex_q.wr == id_rt));
    hold_id = stall_muldiv || loaduse;
  end

  // Next EX contents: hold during mult/div, bubble on squash/hazard/empty slot, else take ID
  always_comb begin
    ex_d = ex_q;
    if (!stall_muldiv) begin
      if (flush || loaduse || !id_valid) begin
        ex_d = '0;
      end else begin
        ex_d.aluop   = id_aluop;
        ex_d.funct   = id_funct;
        ex_d.ctrl    = id_ctrl;
        ex_d.rs      = id_rs;
        ex_d.rt      = id_rt;
        ex_d.wr      = id_wr;
        ex_d.valid   = 1'b1;
        ex_d.rs_data = id_rs_data;
        ex_d.rt_data = id_rt_data;
        ex_d.imm     = id_imm;
      end
    end
  end

  // EX register bank; reset also drops any instruction held by a mult/div stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_rs (
    .src_reg        (ex_q.rs),
    .src_data       (ex_q.rs_data),
    .exmem_regwrite (exmem_regwrite),
    .exmem_wr       (exmem_wr),
    .exmem_data     (exmem_data),
    .memwb_regwrite (memwb_regwrite),
    .memwb_wr       (memwb_wr),
    .memwb_data     (memwb_data),
    .fwd_data       (fwd_a)
  );

  fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_rt (
    .src_reg        (ex_q.rt),
    .src_data       (ex_q.rt_data),
    .exmem_regwrite (exmem_regwrite),
    .exmem_wr       (exmem_wr),
    .exmem_data     (exmem_data),
    .memwb_regwrite (memwb_regwrite),
    .memwb_wr       (memwb_wr),
    .memwb_data     (memwb_data),
    .fwd_data       (fwd_b)
  );

  // ALU operand steering: shifts operate on rt by shamt, others on rs and rt/immediate
  always_comb begin
    if (is_shift(ex_q.aluop, ex_q.funct)) begin
      ALUinA = fwd_b;
      ALUinB = {27'b0, ex_q.imm[10:6]};
    end else begin
      ALUinA = fwd_a;
      ALUinB = ex_q.ctrl[CTRL_ALUSRC] ? ex_q.imm : fwd_b;
    end
  end

  assign ALUOp_regD    = ex_q.aluop;
  assign funct_regD    = ex_q.funct;
  assign ex_ctrl       = ex_q.ctrl[CTRL_W-1:1];
  assign ex_wr         = ex_q.wr;
  assign ex_valid      = ex_q.valid;
  assign ex_store_data = fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: forwarding, load-use, mult/div stall, flush, reset.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_aluop;
  logic [5:0]  id_funct;
  logic [4:0]  id_ctrl;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_wr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic        flush;
  logic        stall_muldiv;
  logic        exmem_regwrite;
  logic [4:0]  exmem_wr;
  logic [31:0] exmem_data;
  logic        memwb_regwrite;
  logic [4:0]  memwb_wr;
  logic [31:0] memwb_data;
  logic [5:0]  ALUOp_regD;
  logic [5:0]  funct_regD;
  logic [31:0] ALUinA;
  logic [31:0] ALUinB;
  logic [3:0]  ex_ctrl;
  logic [4:0]  ex_wr;
  logic [31:0] ex_store_data;
  logic        ex_valid;
  logic        hold_id;

  int checkCount = 0;
  int errorCount = 0;

  id_ex_stage #(.FWD_EN(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_aluop       (id_aluop),
    .id_funct       (id_funct),
    .id_ctrl        (id_ctrl),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_wr          (id_wr),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm         (id_imm),
    .flush          (flush),
    .stall_muldiv   (stall_muldiv),
    .exmem_regwrite (exmem_regwrite),
    .exmem_wr       (exmem_wr),
    .exmem_data     (exmem_data),
    .memwb_regwrite (memwb_regwrite),
    .memwb_wr       (memwb_wr),
    .memwb_data     (memwb_data),
    .ALUOp_regD     (ALUOp_regD),
    .funct_regD     (funct_regD),
    .ALUinA         (ALUinA),
    .ALUinB         (ALUinB),
    .ex_ctrl        (ex_ctrl),
    .ex_wr          (ex_wr),
    .ex_store_data  (ex_store_data),
    .ex_valid       (ex_valid),
    .hold_id        (hold_id)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] ctl, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] wr, input logic [31:0] rsd, input logic [31:0] rtd,
                               input logic [31:0] imm);
    id_valid   = v;
    id_aluop   = op;
    id_funct   = fn;
    id_ctrl    = ctl;
    id_rs      = rs;
    id_rt      = rt;
    id_wr      = wr;
    id_rs_data = rsd;
    id_rt_data = rtd;
    id_imm     = imm;
  endtask

  task automatic clearForward();
    exmem_regwrite = 1'b0;
    exmem_wr       = 5'd0;
    exmem_data     = 32'd0;
    memwb_regwrite = 1'b0;
    memwb_wr       = 5'd0;
    memwb_data     = 32'd0;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " aluop"}, {26'd0, ALUOp_regD}, 32'd0);
    checkOutput({tag, " funct"}, {26'd0, funct_regD}, 32'd0);
    checkOutput({tag, " ALUinA"}, ALUinA, 32'd0);
    checkOutput({tag, " ALUinB"}, ALUinB, 32'd0);
    checkOutput({tag, " ex_ctrl"}, {28'd0, ex_ctrl}, 32'd0);
    checkOutput({tag, " ex_wr"}, {27'd0, ex_wr}, 32'd0);
    checkOutput({tag, " store"}, ex_store_data, 32'd0);
    checkOutput({tag, " ex_valid"}, {31'd0, ex_valid}, 32'd0);
  endtask

  // Directed test sequence
  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    stall_muldiv = 1'b1;
    clearForward();
    applyStimulus(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    #2;
    checkAllZero("reset");
    checkOutput("reset hold_id stall", {31'd0, hold_id}, 32'd1);
    stall_muldiv = 1'b0;
    #1;
    checkOutput("reset hold_id idle", {31'd0, hold_id}, 32'd0);
    stepClock();
    rst_n = 1'b1;
    stepClock();
    checkAllZero("post-reset");

    // Test 1: add r3=r1+r2, then add r6=r3+r1 forwarded from EX/MEM
    applyStimulus(1'b1, OP_RTYPE, FUNCT_ADD, 5'b10000, 5'd1, 5'd2, 5'd3, 32'd3, 32'd4, 32'd0);
    stepClock();
    checkOutput("t1 add ex_wr", {27'd0, ex_wr}, 32'd3);
    checkOutput("t1 add ALUinA", ALUinA, 32'd3);
    checkOutput("t1 add ALUinB", ALUinB, 32'd4);
    applyStimulus(1'b1, OP_RTYPE, FUNCT_ADD, 5'b10000, 5'd3, 5'd1, 5'd6, 32'h99, 32'd3, 32'd0);
    stepClock();
    exmem_regwrite = 1'b1;
    exmem_wr       = 5'd3;
    exmem_data     = 32'h0000_0007;
    #1;
    checkOutput("t1 fwd ALUinA", ALUinA, 32'h0000_0007);
    checkOutput("t1 fwd ALUinB", ALUinB, 32'd3);
    checkOutput("t1 ex_ctrl", {28'd0, ex_ctrl}, 32'h8);
    checkOutput("t1 ex_valid", {31'd0, ex_valid}, 32'd1);
    clearForward();

    // Test 2: lw r4 then add r5=r4+r1 -> one bubble, then MEM/WB forward
    applyStimulus(1'b1, OP_LW, 6'd0, 5'b11011, 5'd1, 5'd4, 5'd4, 32'h100, 32'd0, 32'd8);
    stepClock();
    checkOutput("t2 lw ALUinA", ALUinA, 32'h100);
    checkOutput("t2 lw ALUinB", ALUinB, 32'd8);
    checkOutput("t2 lw ex_ctrl", {28'd0, ex_ctrl}, 32'hD);
    applyStimulus(1'b1, OP_RTYPE, FUNCT_ADD, 5'b10000, 5'd4, 5'd1, 5'd5, 32'd0, 32'd3, 32'd0);
    #1;
    checkOutput("t2 hold_id set", {31'd0, hold_id}, 32'd1);
    stepClock();
    checkOutput("t2 bubble valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("t2 bubble ex_wr", {27'd0, ex_wr}, 32'd0);
    checkOutput("t2 hold_id clear", {31'd0, hold_id}, 32'd0);
    stepClock();
    memwb_regwrite = 1'b1;
    memwb_wr       = 5'd4;
    memwb_data     = 32'hDEAD_BEEF;
    #1;
    checkOutput("t2 fwd ALUinA", ALUinA, 32'hDEAD_BEEF);
    checkOutput("t2 add ALUinB", ALUinB, 32'd3);
    checkOutput("t2 add ex_wr", {27'd0, ex_wr}, 32'd5);
    clearForward();

    // Test 3: mult held for 33 stall cycles, next instruction enters once
    applyStimulus(1'b1, OP_RTYPE, FUNCT_MULT, 5'b00000, 5'd1, 5'd2, 5'd0, 32'd5, 32'd6, 32'd0);
    stepClock();
    checkOutput("t3 mult issued", {26'd0, funct_regD}, {26'd0, FUNCT_MULT});
    applyStimulus(1'b1, OP_RTYPE, FUNCT_ADD, 5'b10000, 5'd1, 5'd2, 5'd7, 32'd5, 32'd6, 32'd0);
    stall_muldiv = 1'b1;
    for (int i = 0; i < 33; i++) begin
      stepClock();
      checkOutput("t3 stall funct", {26'd0, funct_regD}, {26'd0, FUNCT_MULT});
      checkOutput("t3 stall ALUinA", ALUinA, 32'd5);
    end
    checkOutput("t3 stall hold_id", {31'd0, hold_id}, 32'd1);
    stall_muldiv = 1'b0;
    #1;
    checkOutput("t3 release hold_id", {31'd0, hold_id}, 32'd0);
    stepClock();
    checkOutput("t3 next funct", {26'd0, funct_regD}, {26'd0, FUNCT_ADD});
    checkOutput("t3 next ex_wr", {27'd0, ex_wr}, 32'd7);
    applyStimulus(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    stepClock();
    checkOutput("t3 no reissue funct", {26'd0, funct_regD}, 32'd0);
    checkOutput("t3 no reissue valid", {31'd0, ex_valid}, 32'd0);

    // Test 4: flush during stall is deferred until the stall drops
    applyStimulus(1'b1, OP_RTYPE, FUNCT_SUB, 5'b10000, 5'd1, 5'd2, 5'd10, 32'd9, 32'd1, 32'd0);
    stepClock();
    checkOutput("t4 sub ex_wr", {27'd0, ex_wr}, 32'd10);
    applyStimulus(1'b1, OP_RTYPE, FUNCT_ADD, 5'b10000, 5'd1, 5'd2, 5'd9, 32'd9, 32'd1, 32'd0);
    flush        = 1'b1;
    stall_muldiv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stepClock();
      checkOutput("t4 stalled ex_wr", {27'd0, ex_wr}, 32'd10);
      checkOutput("t4 stalled valid", {31'd0, ex_valid}, 32'd1);
    end
    stall_muldiv = 1'b0;
    stepClock();
    checkOutput("t4 flushed valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("t4 flushed ex_wr", {27'd0, ex_wr}, 32'd0);
    checkOutput("t4 flushed funct", {26'd0, funct_regD}, 32'd0);
    flush = 1'b0;

    // Test 5: EX/MEM beats MEM/WB; r0 never forwarded
    applyStimulus(1'b1, OP_RTYPE, FUNCT_ADD, 5'b10000, 5'd8, 5'd0, 5'd11, 32'h55, 32'h66, 32'd0);
    stepClock();
    exmem_regwrite = 1'b1;
    exmem_wr       = 5'd8;
    exmem_data     = 32'h11;
    memwb_regwrite = 1'b1;
    memwb_wr       = 5'd8;
    memwb_data     = 32'h22;
    #1;
    checkOutput("t5 priority ALUinA", ALUinA, 32'h11);
    exmem_regwrite = 1'b0;
    #1;
    checkOutput("t5 memwb ALUinA", ALUinA, 32'h22);
    exmem_regwrite = 1'b1;
    exmem_wr       = 5'd0;
    memwb_wr       = 5'd0;
    #1;
    checkOutput("t5 r0 ALUinA", ALUinA, 32'h55);
    checkOutput("t5 r0 ALUinB", ALUinB, 32'h66);
    checkOutput("t5 r0 store", ex_store_data, 32'h66);
    clearForward();

    // Test 6: sra by 4, then reset while a mult is stalled
    applyStimulus(1'b1, OP_RTYPE, FUNCT_SRA, 5'b10000, 5'd0, 5'd2, 5'd12, 32'd0, 32'h8000_0000, 32'h0000_0100);
    stepClock();
    checkOutput("t6 sra ALUinA", ALUinA, 32'h8000_0000);
    checkOutput("t6 sra ALUinB", ALUinB, 32'h4);
    applyStimulus(1'b1, OP_RTYPE, FUNCT_MULT, 5'b00000, 5'd1, 5'd2, 5'd0, 32'd5, 32'd6, 32'd0);
    stepClock();
    stall_muldiv = 1'b1;
    applyStimulus(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    stepClock();
    checkOutput("t6 stalled funct", {26'd0, funct_regD}, {26'd0, FUNCT_MULT});
    rst_n = 1'b0;
    #1;
    checkAllZero("t6 reset");
    checkOutput("t6 reset hold_id", {31'd0, hold_id}, 32'd1);
    stall_muldiv = 1'b0;
    #1;
    checkOutput("t6 reset hold_id idle", {31'd0, hold_id}, 32'd0);
    stepClock();
    rst_n = 1'b1;
    stepClock();
    checkOutput("t6 after reset funct", {26'd0, funct_regD}, 32'd0);
    checkOutput("t6 after reset valid", {31'd0, ex_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
